// File: rtl/bpsk_tx_pkg.sv
// Shared types and constants for the BPSK transmit framer.
// Frame layout: preamble bytes, sync word, length byte, payload bytes.
package bpsk_tx_pkg;

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SYNC_W = 16;

    localparam logic [SYNC_W-1:0] SYNC_WORD_DEFAULT = 16'hD391;
    localparam logic [7:0]        PREAMBLE_BYTE     = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_LEN      = 3'd3,
        ST_PAYLOAD  = 3'd4
    } state_t;

endpackage

// File: rtl/bpsk_bit_timer.sv
// Bit-period timer: counts 0..SAMPLES_PER_BIT-1 while running.
// It produces the first-clock strobe and the end-of-bit advance pulse.
module bpsk_bit_timer #(
    parameter int unsigned SAMPLES_PER_BIT = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_run,
    output logic o_strobe,
    output logic o_wrap
);

    localparam int unsigned CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // Held at zero while idle so the first bit of a frame starts a full period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (!i_run || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_strobe = i_run & i_en & (r_cnt == '0);
    assign o_wrap   = i_run & i_en & w_last;

endmodule

// File: rtl/bpsk_tx_framer.sv
// Frame builder and MSB-first serialiser feeding the BPSK modulator bit input.
// Payload bytes are prefetched into a one-byte skid buffer ahead of each byte boundary.
module bpsk_tx_framer
    import bpsk_tx_pkg::*;
#(
    parameter int unsigned       SAMPLES_PER_BIT = 20,
    parameter int unsigned       PREAMBLE_BYTES  = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD       = SYNC_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             bit_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_fetch_cnt;
    logic [LEN_W-1:0]  r_tx_cnt;
    logic [7:0]        r_buf;
    logic              r_buf_full;
    logic [SYNC_W-1:0] r_sr;
    logic [3:0]        r_bitn;
    logic [3:0]        r_pre_cnt;
    logic              r_done;
    logic              r_underrun;

    logic w_busy;
    logic w_strobe;
    logic w_adv;
    logic w_start_acc;
    logic w_fetch_win;
    logic w_xfer;
    logic w_chunk_end;
    logic w_pre_last;
    logic w_frame_end;
    logic w_need_byte;
    logic w_underrun_evt;

    bpsk_bit_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_timer (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_run   (w_busy),
        .o_strobe(w_strobe),
        .o_wrap  (w_adv)
    );

    assign w_busy      = (r_state != ST_IDLE);
    assign w_start_acc = en & start & (r_state == ST_IDLE) & ~r_done;
    assign w_fetch_win = w_busy & ((r_state == ST_LEN) | (r_state == ST_PAYLOAD))
                       & ~r_buf_full & (r_fetch_cnt < r_len);
    assign w_xfer      = s_valid & w_fetch_win & en;
    assign w_chunk_end = w_adv & (r_bitn == 4'd0);
    assign w_pre_last  = (r_pre_cnt == 4'(PREAMBLE_BYTES - 1));

    // Decide at the end of the LEN byte or a payload byte whether the frame ends or needs more data.
    always_comb begin
        w_frame_end = 1'b0;
        w_need_byte = 1'b0;
        if (w_chunk_end) begin
            case (r_state)
                ST_LEN: begin
                    if (r_len == '0) w_frame_end = 1'b1;
                    else             w_need_byte = 1'b1;
                end
                ST_PAYLOAD: begin
                    if (r_tx_cnt == r_len) w_frame_end = 1'b1;
                    else                   w_need_byte = 1'b1;
                end
                default: ;
            endcase
        end
        w_underrun_evt = w_need_byte & ~r_buf_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_fetch_cnt <= '0;
            r_tx_cnt    <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_sr        <= '0;
            r_bitn      <= '0;
            r_pre_cnt   <= '0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (en) begin
            r_done <= w_frame_end;

            if (w_xfer) begin
                r_buf       <= s_data;
                r_buf_full  <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        r_state     <= ST_PREAMBLE;
                        r_len       <= len;
                        r_underrun  <= 1'b0;
                        r_sr        <= {PREAMBLE_BYTE, 8'h00};
                        r_bitn      <= 4'd7;
                        r_pre_cnt   <= '0;
                        r_fetch_cnt <= '0;
                        r_tx_cnt    <= '0;
                        r_buf_full  <= 1'b0;
                    end
                end
                default: begin
                    if (w_adv) begin
                        if (r_bitn != 4'd0) begin
                            r_sr   <= {r_sr[SYNC_W-2:0], 1'b0};
                            r_bitn <= r_bitn - 4'd1;
                        end else if (w_frame_end || w_underrun_evt) begin
                            // Any byte caught in flight is dropped along with the frame.
                            r_state    <= ST_IDLE;
                            r_sr       <= '0;
                            r_buf_full <= 1'b0;
                            if (w_underrun_evt) r_underrun <= 1'b1;
                        end else begin
                            case (r_state)
                                ST_PREAMBLE: begin
                                    if (w_pre_last) begin
                                        r_state <= ST_SYNC;
                                        r_sr    <= SYNC_WORD;
                                        r_bitn  <= 4'd15;
                                    end else begin
                                        r_pre_cnt <= r_pre_cnt + 4'd1;
                                        r_sr      <= {PREAMBLE_BYTE, 8'h00};
                                        r_bitn    <= 4'd7;
                                    end
                                end
                                ST_SYNC: begin
                                    r_state <= ST_LEN;
                                    r_sr    <= {r_len, 8'h00};
                                    r_bitn  <= 4'd7;
                                end
                                default: begin
                                    r_state    <= ST_PAYLOAD;
                                    r_sr       <= {r_buf, 8'h00};
                                    r_bitn     <= 4'd7;
                                    r_buf_full <= 1'b0;
                                    r_tx_cnt   <= r_tx_cnt + 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign s_ready    = w_fetch_win;
    assign bit_out    = r_sr[SYNC_W-1];
    assign bit_strobe = w_strobe;
    assign busy       = w_busy;
    assign done       = r_done & en;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Self-checking bench for bpsk_tx_framer: a frame-level bit-list model predicts
// bit_out/bit_strobe/busy/done/underrun on every cycle from the count of enabled clocks.
module tb_bpsk_tx_framer;

    typedef logic [7:0] u8_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_en, a_start, a_svalid, a_sready, a_bit, a_strb, a_busy, a_done, a_ur;
    logic [7:0] a_len, a_sdata;
    logic       b_en, b_start, b_svalid, b_sready, b_bit, b_strb, b_busy, b_done, b_ur;
    logic [7:0] b_len, b_sdata;

    bpsk_tx_framer u_a (
        .clk(clk), .rst(rst), .en(a_en), .start(a_start), .len(a_len),
        .s_data(a_sdata), .s_valid(a_svalid), .s_ready(a_sready),
        .bit_out(a_bit), .bit_strobe(a_strb), .busy(a_busy), .done(a_done), .underrun(a_ur)
    );

    bpsk_tx_framer #(.SAMPLES_PER_BIT(2), .PREAMBLE_BYTES(1)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .start(b_start), .len(b_len),
        .s_data(b_sdata), .s_valid(b_svalid), .s_ready(b_sready),
        .bit_out(b_bit), .bit_strobe(b_strb), .busy(b_busy), .done(b_done), .underrun(b_ur)
    );

    int checks = 0;
    int errors = 0;

    u8_t q_a[$];
    u8_t q_b[$];
    logic hs_a = 1'b0;
    logic hs_b = 1'b0;

    // Reference frame: expected bit list, bit period and terminal condition.
    u8_t  m_pay[$];
    bit   m_bits[$];
    int   m_spb;
    int   m_endp;
    bit   m_ur;

    function automatic void build_model(int spb, int pb, logic [7:0] ln);
        logic [15:0] sw;
        int nb;
        sw = 16'hD391;
        m_bits.delete();
        for (int i = 0; i < 8 * pb; i++) m_bits.push_back(i % 2 == 0);
        for (int i = 15; i >= 0; i--) m_bits.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) m_bits.push_back(ln[i]);
        nb = (m_pay.size() < int'(ln)) ? m_pay.size() : int'(ln);
        for (int k = 0; k < nb; k++)
            for (int i = 7; i >= 0; i--) m_bits.push_back(m_pay[k][i]);
        m_ur   = (m_pay.size() < int'(ln));
        m_spb  = spb;
        m_endp = m_bits.size() * spb;
    endfunction

    // p = number of enabled clock edges since the start was accepted.
    function automatic logic [4:0] exp_vec(int p, logic en_now);
        if (p < m_endp)
            return {m_bits[p / m_spb], ((p % m_spb) == 0) && en_now, 1'b1, 1'b0, 1'b0};
        else
            return {1'b0, 1'b0, 1'b0, (!m_ur && p == m_endp && en_now), m_ur};
    endfunction

    initial begin
        a_svalid = 1'b0;
        a_sdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (hs_a && q_a.size() > 0) void'(q_a.pop_front());
            a_svalid = (q_a.size() > 0);
            if (a_svalid) a_sdata = q_a[0];
            else          a_sdata = 8'($urandom);
            #1 hs_a = a_svalid && a_sready && a_en;
        end
    end

    initial begin
        int idle_b;
        idle_b   = 0;
        b_svalid = 1'b0;
        b_sdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (hs_b && q_b.size() > 0) void'(q_b.pop_front());
            if (q_b.size() > 0) begin
                b_svalid = ($urandom_range(0, 1) == 1) || (idle_b >= 3);
                if (b_svalid) idle_b = 0;
                else          idle_b++;
            end else begin
                b_svalid = 1'b0;
            end
            if (b_svalid) b_sdata = q_b[0];
            else          b_sdata = 8'($urandom);
            #1 hs_b = b_svalid && b_sready && b_en;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_a(input logic [7:0] ln);
        @(negedge clk);
        a_len   = ln;
        a_start = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        a_start = 1'b1;
        #1;
        checks++;
        if ({a_bit, a_strb, a_busy, a_done, a_ur, a_sready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a got %b exp 000000", {a_bit, a_strb, a_busy, a_done, a_ur, a_sready});
        end
        checks++;
        if ({b_bit, b_strb, b_busy, b_done, b_ur, b_sready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_b got %b exp 000000", {b_bit, b_strb, b_busy, b_done, b_ur, b_sready});
        end
        @(negedge clk);
        a_start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int p, first_st, done_at;
        logic [4:0] e;
        m_pay.delete(); m_pay.push_back(8'hA5);
        build_model(20, 4, 8'd1);
        q_a = m_pay;
        start_a(8'd1);
        p = 0; first_st = -1; done_at = -1;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            a_len   = 8'($urandom);
            #1;
            e = exp_vec(p, a_en);
            checks++;
            if ({a_bit, a_strb, a_busy, a_done, a_ur} !== e) begin
                errors++;
                $display("FAIL basic cyc %0d got %b exp %b", c, {a_bit, a_strb, a_busy, a_done, a_ur}, e);
            end
            if (a_strb && first_st < 0) first_st = c;
            if (a_done) done_at = c;
            if (a_en) p++;
        end
        checks++;
        if (done_at - first_st !== 1280) begin
            errors++;
            $display("FAIL basic_done_latency got %0d exp 1280", done_at - first_st);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_len_zero();
        int p, first_st, done_at;
        logic [4:0] e;
        m_pay.delete();
        build_model(20, 4, 8'd0);
        q_a.push_back(8'($urandom));
        start_a(8'd0);
        p = 0; first_st = -1; done_at = -1;
        for (int c = 0; c < 1140; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            #1;
            e = exp_vec(p, a_en);
            checks++;
            if ({a_bit, a_strb, a_busy, a_done, a_ur} !== e) begin
                errors++;
                $display("FAIL len0 cyc %0d got %b exp %b", c, {a_bit, a_strb, a_busy, a_done, a_ur}, e);
            end
            checks++;
            if (a_sready !== 1'b0) begin
                errors++;
                $display("FAIL len0_sready cyc %0d got %b exp 0", c, a_sready);
            end
            if (a_strb && first_st < 0) first_st = c;
            if (a_done) done_at = c;
            if (a_en) p++;
        end
        checks++;
        if (done_at - first_st !== 1120) begin
            errors++;
            $display("FAIL len0_done_latency got %0d exp 1120", done_at - first_st);
        end
        q_a.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_underrun();
        int p, done_at;
        logic [4:0] e;
        m_pay.delete(); m_pay.push_back(8'h3C);
        build_model(20, 4, 8'd2);
        q_a = m_pay;
        start_a(8'd2);
        p = 0; done_at = -1;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            #1;
            e = exp_vec(p, a_en);
            checks++;
            if ({a_bit, a_strb, a_busy, a_done, a_ur} !== e) begin
                errors++;
                $display("FAIL underrun cyc %0d got %b exp %b", c, {a_bit, a_strb, a_busy, a_done, a_ur}, e);
            end
            if (a_done) done_at = c;
            if (a_en) p++;
        end
        checks++;
        if (done_at !== -1) begin
            errors++;
            $display("FAIL underrun_no_done got done at %0d exp none", done_at);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_en_freeze();
        int p, first_st, done_at;
        logic [4:0] e;
        m_pay.delete(); m_pay.push_back(8'($urandom));
        build_model(20, 4, 8'd1);
        q_a = m_pay;
        start_a(8'd1);
        p = 0; first_st = -1; done_at = -1;
        for (int c = 0; c < 1350; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            a_en    = !(c >= 700 && c < 750);
            #1;
            e = exp_vec(p, a_en);
            checks++;
            if ({a_bit, a_strb, a_busy, a_done, a_ur} !== e) begin
                errors++;
                $display("FAIL en_freeze cyc %0d got %b exp %b", c, {a_bit, a_strb, a_busy, a_done, a_ur}, e);
            end
            if (a_strb && first_st < 0) first_st = c;
            if (a_done) done_at = c;
            if (a_en) p++;
        end
        checks++;
        if (done_at - first_st !== 1330) begin
            errors++;
            $display("FAIL en_freeze_done_latency got %0d exp 1330", done_at - first_st);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int p, first_st, done_at;
        logic [4:0] e;
        m_pay.delete();
        m_pay.push_back(8'($urandom)); m_pay.push_back(8'($urandom));
        build_model(20, 4, 8'd2);
        q_a = m_pay;
        start_a(8'd2);
        p = 0;
        for (int c = 0; c <= 1150; c++) begin
            @(negedge clk);
            a_start = (c == 100);
            #1;
            e = exp_vec(p, a_en);
            checks++;
            if ({a_bit, a_strb, a_busy, a_done, a_ur} !== e) begin
                errors++;
                $display("FAIL busy_start cyc %0d got %b exp %b", c, {a_bit, a_strb, a_busy, a_done, a_ur}, e);
            end
            if (a_en) p++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a_bit, a_strb, a_busy, a_done, a_ur, a_sready} !== 6'b0) begin
            errors++;
            $display("FAIL midframe_rst got %b exp 000000", {a_bit, a_strb, a_busy, a_done, a_ur, a_sready});
        end
        repeat (2) @(negedge clk);
        q_a.delete();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({a_bit, a_busy, a_done, a_ur} !== 4'b0) begin
                errors++;
                $display("FAIL post_rst_idle cyc %0d got %b exp 0000", c, {a_bit, a_busy, a_done, a_ur});
            end
        end
        m_pay.delete(); m_pay.push_back(8'h5A);
        build_model(20, 4, 8'd1);
        q_a = m_pay;
        start_a(8'd1);
        p = 0; first_st = -1; done_at = -1;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            #1;
            e = exp_vec(p, a_en);
            checks++;
            if ({a_bit, a_strb, a_busy, a_done, a_ur} !== e) begin
                errors++;
                $display("FAIL post_rst_frame cyc %0d got %b exp %b", c, {a_bit, a_strb, a_busy, a_done, a_ur}, e);
            end
            if (a_strb && first_st < 0) first_st = c;
            if (a_done) done_at = c;
            if (a_en) p++;
        end
        checks++;
        if (done_at - first_st !== 1280) begin
            errors++;
            $display("FAIL post_rst_done_latency got %0d exp 1280", done_at - first_st);
        end
    endtask

    task automatic test_small_params();
        int p, first_st, done_at;
        logic [4:0] e;
        m_pay.delete();
        m_pay.push_back(8'h00); m_pay.push_back(8'hFF); m_pay.push_back(8'h81);
        build_model(2, 1, 8'd3);
        q_b = m_pay;
        @(negedge clk);
        b_len   = 8'd3;
        b_start = 1'b1;
        p = 0; first_st = -1; done_at = -1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_len   = 8'($urandom);
            #1;
            e = exp_vec(p, b_en);
            checks++;
            if ({b_bit, b_strb, b_busy, b_done, b_ur} !== e) begin
                errors++;
                $display("FAIL small cyc %0d got %b exp %b", c, {b_bit, b_strb, b_busy, b_done, b_ur}, e);
            end
            if (b_strb && first_st < 0) first_st = c;
            if (b_done) done_at = c;
            if (b_en) p++;
        end
        checks++;
        if (done_at - first_st !== 112) begin
            errors++;
            $display("FAIL small_done_latency got %0d exp 112", done_at - first_st);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_en    = 1'b1;
        a_start = 1'b0;
        a_len   = 8'h00;
        b_en    = 1'b1;
        b_start = 1'b0;
        b_len   = 8'h00;
        test_reset();
        test_basic();
        test_len_zero();
        test_underrun();
        test_en_freeze();
        test_reset_midframe();
        test_small_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
